// File: rtl/forwarding.sv
// Operand forwarding select generator: compares decode-stage sources against
// EX/MEM/WB destinations and registers a 2-bit bypass select per operand.
module forwarding #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_d,
    input  logic [ADDR_W-1:0] rs2_d,
    input  logic [ADDR_W-1:0] rd_EX,
    input  logic [ADDR_W-1:0] rd_MEM,
    input  logic [ADDR_W-1:0] rd_WB,
    output logic [1:0]        ID_EX,
    output logic [1:0]        MEM_EX
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    // Register 0 is hard-wired zero, so neither a zero source nor a zero
    // destination may ever produce a forward.
    function automatic logic [1:0] pick_sel(
        input logic [ADDR_W-1:0] rs,
        input logic [ADDR_W-1:0] ex,
        input logic [ADDR_W-1:0] mem,
        input logic [ADDR_W-1:0] wb
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (rs != '0) begin
            if (rs == ex)
                sel = SEL_EX;
            else if (rs == mem)
                sel = SEL_MEM;
            else if (rs == wb)
                sel = SEL_WB;
        end
        return sel;
    endfunction

    logic [1:0] sel_rs1;
    logic [1:0] sel_rs2;

    always_comb begin
        sel_rs1 = pick_sel(rs1_d, rd_EX, rd_MEM, rd_WB);
        sel_rs2 = pick_sel(rs2_d, rd_EX, rd_MEM, rd_WB);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ID_EX  <= SEL_RF;
            MEM_EX <= SEL_RF;
        end else begin
            ID_EX  <= sel_rs1;
            MEM_EX <= sel_rs2;
        end
    end

endmodule

// File: tb/tb_forwarding.sv
// Directed + random bench for forwarding; expected selects are queued at
// drive time and popped one edge later.
module tb_forwarding;

    localparam int ADDR_W = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] rs1_d = '0;
    logic [ADDR_W-1:0] rs2_d = '0;
    logic [ADDR_W-1:0] rd_EX = '0;
    logic [ADDR_W-1:0] rd_MEM = '0;
    logic [ADDR_W-1:0] rd_WB = '0;
    logic [1:0]        ID_EX;
    logic [1:0]        MEM_EX;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] exp_q[$];
    logic [3:0] last_exp = 4'b0000;

    forwarding #(.ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .rs1_d  (rs1_d),
        .rs2_d  (rs2_d),
        .rd_EX  (rd_EX),
        .rd_MEM (rd_MEM),
        .rd_WB  (rd_WB),
        .ID_EX  (ID_EX),
        .MEM_EX (MEM_EX)
    );

    always #5 clk = ~clk;

    // Reference: oldest producer first, younger stages overwrite the choice.
    function automatic logic [1:0] model_sel(
        input logic [ADDR_W-1:0] rs,
        input logic [ADDR_W-1:0] ex,
        input logic [ADDR_W-1:0] mem,
        input logic [ADDR_W-1:0] wb
    );
        logic [1:0] r;
        r = 2'd0;
        if (wb  == rs && wb  != 0) r = 2'd3;
        if (mem == rs && mem != 0) r = 2'd2;
        if (ex  == rs && ex  != 0) r = 2'd1;
        if (rs == 0) r = 2'd0;
        return r;
    endfunction

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic step(input string tag,
                        input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                        input logic [ADDR_W-1:0] ex, input logic [ADDR_W-1:0] mem,
                        input logic [ADDR_W-1:0] wb);
        logic [3:0] e;
        @(negedge clk);
        rs1_d = a; rs2_d = b; rd_EX = ex; rd_MEM = mem; rd_WB = wb;
        exp_q.push_back({model_sel(a, ex, mem, wb), model_sel(b, ex, mem, wb)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        last_exp = e;
        check({tag, ".ID_EX"}, ID_EX, e[3:2]);
        check({tag, ".MEM_EX"}, MEM_EX, e[1:0]);
    endtask

    initial begin
        // Async reset without any clock edge (first posedge is at t=5).
        rs1_d = 7'd5; rs2_d = 7'd5; rd_EX = 7'd5;
        #1 rst = 1'b1;
        #1;
        check("rst_async.ID_EX", ID_EX, 2'b00);
        check("rst_async.MEM_EX", MEM_EX, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        step("all_zero",   7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
        step("ex_fwd",     7'd2, 7'd3, 7'd3, 7'd0, 7'd0);
        step("mem_fwd",    7'd2, 7'd3, 7'd0, 7'd3, 7'd0);
        step("wb_fwd",     7'd2, 7'd3, 7'd0, 7'd3, 7'd2);
        step("all_same",   7'd5, 7'd5, 7'd5, 7'd5, 7'd5);
        step("mem_wb",     7'd5, 7'd5, 7'd0, 7'd5, 7'd5);
        step("wb_only",    7'd5, 7'd5, 7'd0, 7'd0, 7'd5);
        step("zero_src",   7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
        step("full_width", 7'h41, 7'h7F, 7'h01, 7'h3F, 7'h7E);
        step("top_bit",    7'h7F, 7'h40, 7'h7F, 7'h40, 7'h40);

        // Mid-cycle input changes must not reach the outputs.
        step("pre_mid", 7'd9, 7'd10, 7'd9, 7'd10, 7'd0);
        #2;
        rs1_d = 7'd0; rs2_d = 7'd4; rd_EX = 7'd4; rd_MEM = 7'd0; rd_WB = 7'd0;
        #1;
        check("mid_hold.ID_EX", ID_EX, last_exp[3:2]);
        check("mid_hold.MEM_EX", MEM_EX, last_exp[1:0]);

        // Async reset between edges clears at once.
        rst = 1'b1;
        #1;
        check("rst_mid.ID_EX", ID_EX, 2'b00);
        check("rst_mid.MEM_EX", MEM_EX, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 7'd6, 7'd7, 7'd0, 7'd6, 7'd7);

        for (int i = 0; i < 40; i++) begin
            step("rand",
                 ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)),
                 ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)),
                 ADDR_W'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/forwarding.md
FORWARDING -- requirements
Module: forwarding

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, giving the register-address width of all address inputs.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port rs1_d, input, ADDR_W bits: source register 1 address of the instruction in decode.
REQ-005 The block SHALL have port rs2_d, input, ADDR_W bits: source register 2 address of the instruction in decode.
REQ-006 The block SHALL have port rd_EX, input, ADDR_W bits: destination register of the instruction in execute.
REQ-007 The block SHALL have port rd_MEM, input, ADDR_W bits: destination register of the instruction in memory.
REQ-008 The block SHALL have port rd_WB, input, ADDR_W bits: destination register of the instruction in writeback.
REQ-009 The block SHALL have port ID_EX, output, 2 bits: registered forwarding select for operand rs1.
REQ-010 The block SHALL have port MEM_EX, output, 2 bits: registered forwarding select for operand rs2.

Function
REQ-011 Both select outputs SHALL use one encoding:
- 00: no forward (use register-file value)
- 01: forward from the EX-stage result (rd_EX)
- 10: forward from the MEM-stage result (rd_MEM)
- 11: forward from the WB-stage result (rd_WB)
REQ-012 For each operand rsX (rs1_d drives ID_EX, rs2_d drives MEM_EX), the next select SHALL be, in priority order:
- 01 if rsX equals rd_EX
- else 10 if rsX equals rd_MEM
- else 11 if rsX equals rd_WB
- else 00
REQ-013 Address 0 is the hard-wired zero register: if rsX is 0, the select SHALL be 00 regardless of any stage destination.
REQ-014 A stage destination of 0 SHALL never match, so 0 means "no write".
REQ-015 Comparisons SHALL be full-width ADDR_W equality, with no truncation.
REQ-016 The two operands SHALL be evaluated independently, in parallel, in the same cycle; rs1_d equal to rs2_d SHALL yield identical selects.
REQ-017 When several stages match, the youngest producer SHALL win: EX beats MEM, MEM beats WB. The same address in all three stages SHALL give 01.
REQ-018 Selects SHALL be computed combinationally from the current inputs and captured into the output registers on each rising clk edge.
REQ-019 Latency SHALL be exactly one cycle: inputs sampled at edge N appear on ID_EX/MEM_EX after edge N and hold until edge N+1.
REQ-020 Outputs SHALL be glitch-free register outputs; input changes between edges SHALL NOT affect the outputs until the next edge.
REQ-021 The block SHALL have no handshake and no stall input; it updates every cycle.

Reset
REQ-022 While rst is high, ID_EX and MEM_EX SHALL be 00 immediately, without waiting for a clk edge.
REQ-023 Asserting rst mid-operation SHALL clear both outputs to 00 asynchronously.
REQ-024 On the first rising edge after rst deasserts, the outputs SHALL load the selects computed from the inputs at that edge.
REQ-025 No other state exists; no reset-release sequencing is required.

Verification
REQ-026 rst=1 with any inputs, no clk edge -> ID_EX=00, MEM_EX=00.
REQ-027 All inputs 0, one edge -> ID_EX=00, MEM_EX=00 (zero register never forwarded).
REQ-028 rs1_d=2, rs2_d=3, rd_EX=3, rd_MEM=0, rd_WB=0, edge -> ID_EX=00, MEM_EX=01.
REQ-029 rs1_d=2, rs2_d=3, rd_EX=0, rd_MEM=3, rd_WB=0, edge -> ID_EX=00, MEM_EX=10. rd_WB=2 with other inputs unchanged, edge -> ID_EX=11.
REQ-030 rs1_d=rs2_d=5, rd_EX=rd_MEM=rd_WB=5, edge -> both 01. Then rd_EX=0 -> both 10. Then rd_MEM=0 -> both 11.
REQ-031 Change inputs mid-cycle -> outputs unchanged until the next rising edge. Assert rst between edges -> both outputs drop to 00 at once.
